// File: rtl/acc_serializer.sv
// Accumulator serializer: captures NU_COUNT accumulators into a shadow bank and
// streams them as rounded, saturated fixed-point words, one per handshake.
module acc_serializer #(
   parameter int NU_COUNT   = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int FRAC_SHIFT = 8,
   localparam int IDX_W     = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          update,
   input  logic [NU_COUNT*ACC_WIDTH-1:0] acc_in,
   output logic                          update_ready,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic [IDX_W-1:0]              out_index,
   output logic                          out_last,
   output logic                          out_sat,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          drop_err
);

   typedef enum logic {IDLE, DRAIN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NU_COUNT - 1);
   localparam logic signed [ACC_WIDTH:0] MAX_V =
      {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] MIN_V = ~MAX_V;

   state_t                 state;
   logic                   shadow_full;
   logic [IDX_W-1:0]       idx;
   logic [ACC_WIDTH-1:0]   shadow_bank [NU_COUNT];
   logic [ACC_WIDTH-1:0]   active_bank [NU_COUNT];
   logic                   accept;
   logic                   load;
   logic signed [ACC_WIDTH:0] lane_ext;
   logic signed [ACC_WIDTH:0] rounded;

   assign accept = update && !shadow_full;
   // Transfer from idle, or back-to-back on the last handshake of a drain.
   assign load   = shadow_full &&
                   ((state == IDLE) || (out_ready && (idx == LAST_IDX)));

   // NOTE: the banks are plain data storage with no reset; validity is carried
   // entirely by shadow_full and state, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NU_COUNT; i++) begin
            shadow_bank[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
         end
      end
      if (load) begin
         active_bank <= shadow_bank;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shadow_full <= 1'b0;
         idx         <= '0;
         drop_err    <= 1'b0;
      end else begin
         if (update && shadow_full) begin
            drop_err <= 1'b1;
         end
         if (load) begin
            shadow_full <= 1'b0;
         end else if (accept) begin
            shadow_full <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (shadow_full) begin
                  state <= DRAIN;
                  idx   <= '0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (idx != LAST_IDX) begin
                     idx <= idx + 1'b1;
                  end else begin
                     idx <= '0;
                     if (!shadow_full) begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign lane_ext = {active_bank[idx][ACC_WIDTH-1], active_bank[idx]};

   generate
      if (FRAC_SHIFT > 0) begin : g_round
         localparam logic signed [ACC_WIDTH:0] HALF =
            (ACC_WIDTH + 1)'(1) << (FRAC_SHIFT - 1);
         assign rounded = (lane_ext + HALF) >>> FRAC_SHIFT;
      end else begin : g_pass
         assign rounded = lane_ext;
      end
   endgenerate

   // NOTE: every output of this block gets a default first, so no path
   // through the if-chain can leave a value unassigned and infer a latch.
   always_comb begin
      out_data = '0;
      out_sat  = 1'b0;
      if (state == DRAIN) begin
         if (rounded > MAX_V) begin
            out_data = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            out_sat  = 1'b1;
         end else if (rounded < MIN_V) begin
            out_data = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            out_sat  = 1'b1;
         end else begin
            out_data = rounded[OUT_WIDTH-1:0];
         end
      end
   end

   assign update_ready = !shadow_full;
   assign out_valid    = (state == DRAIN);
   assign out_index    = idx;
   assign out_last     = (state == DRAIN) && (idx == LAST_IDX);
   assign busy         = shadow_full || (state == DRAIN);

endmodule

// File: tb/tb_acc_serializer.sv
// Scoreboard bench for acc_serializer: directed accumulator sets with
// hand-computed rounded/saturated words, checked by an independent monitor.
module tb_acc_serializer;

   localparam int NU = 4;
   localparam int AW = 32;
   localparam int OW = 16;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  idx;
      logic        last;
      logic        sat;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            update = 1'b0;
   logic [NU*AW-1:0] acc_in = '0;
   logic            update_ready, out_last, out_sat, out_valid, busy, drop_err;
   logic            out_ready = 1'b1;
   logic [OW-1:0]   out_data;
   logic [1:0]      out_index;

   logic            update0 = 1'b0;
   logic [NU*AW-1:0] acc_in0 = '0;
   logic            update_ready0, out_last0, out_sat0, out_valid0, busy0, drop_err0;
   logic [OW-1:0]   out_data0;
   logic [1:0]      out_index0;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   acc_serializer #(.NU_COUNT(NU), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FRAC_SHIFT(8)) u_dut (
      .clk(clk), .reset(reset), .update(update), .acc_in(acc_in),
      .update_ready(update_ready), .out_data(out_data), .out_index(out_index),
      .out_last(out_last), .out_sat(out_sat), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .drop_err(drop_err));

   acc_serializer #(.NU_COUNT(NU), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FRAC_SHIFT(0)) u_dut0 (
      .clk(clk), .reset(reset), .update(update0), .acc_in(acc_in0),
      .update_ready(update_ready0), .out_data(out_data0), .out_index(out_index0),
      .out_last(out_last0), .out_sat(out_sat0), .out_valid(out_valid0),
      .out_ready(1'b1), .busy(busy0), .drop_err(drop_err0));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NU*AW-1:0] pack(input logic [31:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic push(input logic [15:0] d, input logic [1:0] i, input logic s);
      exp_t e;
      e.data = d;
      e.idx  = i;
      e.last = (i == 2'd3);
      e.sat  = s;
      sb.push_back(e);
   endtask

   // Lanes {0x180, -384, max, min}
   task automatic push_set_a();
      push(16'h0002, 2'd0, 1'b0);
      push(16'hFFFF, 2'd1, 1'b0);
      push(16'h7FFF, 2'd2, 1'b1);
      push(16'h8000, 2'd3, 1'b1);
   endtask

   // Rounding half-up boundaries {0x7F, 0x80, -0x80, -0x81}
   task automatic push_set_b();
      push(16'h0000, 2'd0, 1'b0);
      push(16'h0001, 2'd1, 1'b0);
      push(16'h0000, 2'd2, 1'b0);
      push(16'hFFFF, 2'd3, 1'b0);
   endtask

   // Saturation boundaries just inside/outside the 16-bit range
   task automatic push_set_c();
      push(16'h7FFF, 2'd0, 1'b0);
      push(16'h7FFF, 2'd1, 1'b1);
      push(16'h8000, 2'd2, 1'b0);
      push(16'h8000, 2'd3, 1'b1);
   endtask

   localparam logic [NU*AW-1:0] SET_A = {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFE80, 32'h00000180};
   localparam logic [NU*AW-1:0] SET_B = {32'hFFFFFF7F, 32'hFFFFFF80, 32'h00000080, 32'h0000007F};
   localparam logic [NU*AW-1:0] SET_C = {32'hFF7FFF7F, 32'hFF800000, 32'h007FFF80, 32'h007FFF7F};

   task automatic wait_idx(input logic [1:0] want);
      logic found = 1'b0;
      for (int n = 0; n < 50 && !found; n++) begin
         if (out_valid && out_index == want) found = 1'b1;
         else step();
      end
      check($sformatf("wait lane %0d", want), 32'(found), 32'd1);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 60 && busy; n++) step();
      check("idle busy", 32'(busy), 32'd0);
      check("idle out_valid", 32'(out_valid), 32'd0);
   endtask

   // Monitor: a handshake completes at the next edge when valid&ready here.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got data 0x%0h idx %0d with empty scoreboard", out_data, out_index);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out word {data,idx,last,sat}",
                  {12'd0, out_data, out_index, out_last, out_sat},
                  {12'd0, e.data, e.idx, e.last, e.sat});
         end
      end
   end

   logic [15:0] exp0_data [NU];
   logic        exp0_sat  [NU];

   initial begin
      #2;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset update_ready", 32'(update_ready), 32'd1);
      check("reset busy/drop/last/sat", {28'd0, busy, drop_err, out_last, out_sat}, 32'd0);
      check("reset data/index", {14'd0, out_data, out_index}, 32'd0);
      step();
      reset = 1'b0;
      step();

      // Single set, latency and conversion.
      acc_in = SET_A; update = 1'b1; push_set_a();
      step();
      update = 1'b0;
      check("cycle1 out_valid", 32'(out_valid), 32'd0);
      check("cycle1 update_ready", 32'(update_ready), 32'd0);
      check("cycle1 busy", 32'(busy), 32'd1);
      step();
      check("cycle2 out_valid", 32'(out_valid), 32'd1);
      check("cycle2 out_index", 32'(out_index), 32'd0);
      wait_idle();

      // Back-to-back: next set captured while lane 1 drains.
      acc_in = SET_A; update = 1'b1; push_set_a();
      step();
      update = 1'b0;
      wait_idx(2'd1);
      check("b2b update_ready", 32'(update_ready), 32'd1);
      acc_in = SET_B; update = 1'b1; push_set_b();
      step();
      update = 1'b0;
      wait_idx(2'd3);
      step();
      check("b2b no bubble valid", 32'(out_valid), 32'd1);
      check("b2b set2 lane0", 32'(out_index), 32'd0);
      wait_idle();

      // Backpressure on lane 2.
      acc_in = SET_C; update = 1'b1; push_set_c();
      step();
      update = 1'b0;
      wait_idx(2'd2);
      out_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         step();
         check("stall hold", {14'd0, out_data, out_index}, {14'd0, 16'h8000, 2'd2});
         check("stall valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      step();
      check("after stall lane3", 32'(out_index), 32'd3);
      wait_idle();

      // Overflow drop with the consumer stalled.
      out_ready = 1'b0;
      acc_in = SET_A; update = 1'b1; push_set_a();
      step();
      update = 1'b0;
      check("ovf shadow full", 32'(update_ready), 32'd0);
      step();
      check("ovf after transfer ready", 32'(update_ready), 32'd1);
      acc_in = SET_B; update = 1'b1; push_set_b();
      step();
      check("ovf second accepted", {30'd0, update_ready, drop_err}, 32'd0);
      acc_in = SET_C;
      step();
      update = 1'b0;
      check("ovf third dropped", 32'(drop_err), 32'd1);
      out_ready = 1'b1;
      wait_idle();
      check("drop_err sticky", 32'(drop_err), 32'd1);

      // No-shift instance.
      acc_in0 = {32'hFFFF7FFF, 32'h00007FFF, 32'hFFFF8000, 32'h00012345};
      exp0_data = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      exp0_sat  = '{1'b1, 1'b0, 1'b0, 1'b1};
      update0 = 1'b1;
      step();
      update0 = 1'b0;
      step();
      for (int i = 0; i < NU; i++) begin
         check($sformatf("shift0 lane%0d valid/idx", i), {29'd0, out_valid0, out_index0}, {29'd0, 1'b1, 2'(i)});
         check($sformatf("shift0 lane%0d data/sat", i), {15'd0, out_data0, out_sat0}, {15'd0, exp0_data[i], exp0_sat[i]});
         step();
      end
      check("shift0 idle", 32'(busy0), 32'd0);

      // Reset while lane 1 is being handed over.
      acc_in = SET_A; update = 1'b1; push_set_a();
      step();
      update = 1'b0;
      wait_idx(2'd1);
      reset = 1'b1;
      sb.delete();
      #1;
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset ready/busy/drop", {29'd0, update_ready, busy, drop_err}, 32'b100);
      step();
      reset = 1'b0;
      step();
      acc_in = SET_A; update = 1'b1; push_set_a();
      step();
      update = 1'b0;
      wait_idle();
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
